// File: rtl/mem_pkg.sv
// Shared types for the data memory controller: FSM states and byte-lane names.
package mem_pkg;

  // Controller states. IDLE and RESP both accept a new request; BUSY does not.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Little-endian byte lanes within a word, selected by address bits [1:0].
  // LANE_0 is bits [7:0], LANE_3 is bits [31:24].
  typedef enum logic [1:0] {
    LANE_0 = 2'd0,
    LANE_1 = 2'd1,
    LANE_2 = 2'd2,
    LANE_3 = 2'd3
  } lane_e;

  // Width of one byte lane.
  localparam int BYTE_W = 8;

endpackage

// File: rtl/word_ram.sv
// Word-organised storage array with per-byte write enables.
// Synchronous write, combinational read on a single shared address.
// The array has no reset: contents are undefined until written.
module word_ram
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [DATA_WIDTH/8-1:0]        be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic [DATA_WIDTH-1:0]          rdata
);

  localparam int NB = DATA_WIDTH / BYTE_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Write only the byte lanes whose enable is set; other lanes keep their value.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with a valid/ready request channel and a fixed
// response latency. Serves word and byte loads/stores and flags misaligned
// word accesses and addresses beyond the end of the array.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// The requester holds all req_* fields stable until that edge; req_valid while
// req_ready is low is ignored. resp_valid is a single-cycle pulse with no
// backpressure; resp_rdata/resp_error are meaningful only while it is high.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_byte,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [1:0]            state_dbg
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int NB    = DATA_WIDTH / BYTE_W;
  // Counter must hold LATENCY-1; keep it at least one bit wide for LATENCY=1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  // One extra bit so the first illegal byte address is representable.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(DEPTH_WORDS * 4);

  state_e           state;
  state_e           state_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic             accept;
  logic             access;

  logic                  write_q;
  logic                  byte_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  lane_e                 lane;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  err;
  logic                  ram_we;
  logic [NB-1:0]         ram_be;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [BYTE_W-1:0]     byte_val;
  logic [DATA_WIDTH-1:0] access_rdata;

  assign req_ready = (state != BUSY);
  assign accept    = req_valid && req_ready;
  // The array is touched on the last BUSY edge, LATENCY edges after acceptance.
  assign access    = (state == BUSY) && (count == '0);
  assign state_dbg = state;

  // State and latency counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
    end
  end

  // Next-state logic: count down in BUSY, allow back-to-back acceptance from RESP.
  always_comb begin
    state_d = state;
    count_d = count;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          count_d = CNT_LOAD;
        end
      end
      BUSY: begin
        if (count == '0) begin
          state_d = RESP;
        end else begin
          count_d = count - 1'b1;
        end
      end
      RESP: begin
        if (accept) begin
          state_d = BUSY;
          count_d = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the request on acceptance so the requester is free afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= req_write;
      byte_q  <= req_byte;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Address checks, write lane steering and load data extraction.
  always_comb begin
    lane         = lane_e'(addr_q[1:0]);
    out_of_range = ({1'b0, addr_q} >= ADDR_LIMIT);
    misaligned   = !byte_q && (lane != LANE_0);
    err          = out_of_range || misaligned;

    ram_we       = access && write_q && !err;
    ram_be       = byte_q ? ({{(NB-1){1'b0}}, 1'b1} << addr_q[1:0]) : {NB{1'b1}};
    // Replicating the byte to every lane lets the enable alone pick the target.
    ram_wdata    = byte_q ? {NB{wdata_q[BYTE_W-1:0]}} : wdata_q;

    byte_val     = BYTE_W'(ram_rdata >> {addr_q[1:0], 3'b000});

    access_rdata = '0;
    if (!err && !write_q) begin
      access_rdata = byte_q ? DATA_WIDTH'(byte_val) : ram_rdata;
    end
  end

  // Response registers: pulse valid on the access edge, hold data until the next access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= access;
      if (access) begin
        resp_rdata <= access_rdata;
        resp_error <= err;
      end
    end
  end

  word_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_word_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (addr_q[IDX_W+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl (32-bit words, 64 words, latency 2).
module tb_data_memory_ctrl;
  import mem_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 64;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [1:0]  state_dbg;

  int checks;
  int fails;

  // Byte-level reference memory, filled before random traffic.
  logic [7:0]  mb [0:DEPTH*4-1];
  logic [32:0] exp_q [$];

  data_memory_ctrl #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_byte   (req_byte),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .state_dbg  (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Reference model: applies one access to the byte array, returns expected response.
  function automatic void model_access(input logic w, input logic b, input logic [31:0] a,
                                       input logic [31:0] d, output logic [31:0] rd,
                                       output logic er);
    rd = 32'h0;
    er = (a >= DEPTH * 4) || (!b && a[1:0] != 2'b00);
    if (!er) begin
      if (w) begin
        if (b) mb[a] = d[7:0];
        else for (int i = 0; i < 4; i++) mb[a + i] = d[8*i +: 8];
      end else begin
        if (b) rd = {24'h0, mb[a]};
        else rd = {mb[a + 3], mb[a + 2], mb[a + 1], mb[a]};
      end
    end
  endfunction

  // Driver: issue one request, wait for its response. lat = edges from acceptance
  // to the edge raising resp_valid; busy = cycles req_ready was low meanwhile.
  task automatic do_access(input logic w, input logic b, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic er, output int lat, output int busy);
    int g;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_byte  = b;
    req_addr  = a;
    req_wdata = d;
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_byte  = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    rd   = 'x;
    er   = 1'bx;
    lat  = -1;
    busy = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k - 1;
        rd  = resp_rdata;
        er  = resp_error;
        break;
      end
      if (!req_ready) busy++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic er;
    int lat, busy;
    reset = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_byte  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    #13;
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    checks++; if (resp_error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", resp_error); end
    checks++; if (state_dbg !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
    @(negedge clk);
    reset = 1'b1;
    do_access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat, busy);
    checks++; if (lat !== LAT) begin fails++; $display("FAIL first_latency: got %0d want %0d", lat, LAT); end
    checks++; if (busy !== LAT) begin fails++; $display("FAIL first_busy: got %0d want %0d", busy, LAT); end
    checks++; if (er !== 1'b0) begin fails++; $display("FAIL first_store_err: got %b want 0", er); end
    checks++; if (rd !== 32'h0) begin fails++; $display("FAIL first_store_rdata: got %h want 0", rd); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL pulse_width: got %b want 0", resp_valid); end
  endtask

  task automatic test_loads();
    logic [31:0] rd;
    logic er;
    int lat, busy;
    do_access(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, busy);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin fails++; $display("FAIL load_word_10: got %h/%b want deadbeef/0", rd, er); end
    do_access(1'b0, 1'b1, 32'h11, 32'h0, rd, er, lat, busy);
    checks++; if (rd !== 32'h000000BE || er !== 1'b0) begin fails++; $display("FAIL load_byte_11: got %h/%b want 000000be/0", rd, er); end
    do_access(1'b0, 1'b1, 32'h13, 32'h0, rd, er, lat, busy);
    checks++; if (rd !== 32'h000000DE || er !== 1'b0) begin fails++; $display("FAIL load_byte_13: got %h/%b want 000000de/0", rd, er); end
    do_access(1'b0, 1'b1, 32'h10, 32'h0, rd, er, lat, busy);
    checks++; if (rd !== 32'h000000EF) begin fails++; $display("FAIL load_byte_10: got %h want 000000ef", rd); end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd;
    logic er;
    int lat, busy;
    do_access(1'b1, 1'b1, 32'h12, 32'hFFFFFF5A, rd, er, lat, busy);
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin fails++; $display("FAIL byte_store_resp: got %h/%b want 0/0", rd, er); end
    do_access(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, busy);
    checks++; if (rd !== 32'hDE5ABEEF) begin fails++; $display("FAIL byte_merge: got %h want de5abeef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic er;
    int lat, busy;
    do_access(1'b1, 1'b0, 32'h00, 32'h11111111, rd, er, lat, busy);
    do_access(1'b1, 1'b0, 32'hFC, 32'hA5A5C3C3, rd, er, lat, busy);
    do_access(1'b0, 1'b0, 32'h06, 32'h0, rd, er, lat, busy);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin fails++; $display("FAIL misaligned_load: got %h/%b want 0/1", rd, er); end
    checks++; if (lat !== LAT) begin fails++; $display("FAIL error_latency: got %0d want %0d", lat, LAT); end
    do_access(1'b1, 1'b0, 32'h100, 32'h77777777, rd, er, lat, busy);
    checks++; if (er !== 1'b1) begin fails++; $display("FAIL range_store: got %b want 1", er); end
    do_access(1'b1, 1'b1, 32'h101, 32'h00000066, rd, er, lat, busy);
    checks++; if (er !== 1'b1) begin fails++; $display("FAIL range_byte_store: got %b want 1", er); end
    do_access(1'b1, 1'b0, 32'hFE, 32'h99999999, rd, er, lat, busy);
    checks++; if (er !== 1'b1) begin fails++; $display("FAIL misaligned_store: got %b want 1", er); end
    do_access(1'b0, 1'b0, 32'hFC, 32'h0, rd, er, lat, busy);
    checks++; if (rd !== 32'hA5A5C3C3 || er !== 1'b0) begin fails++; $display("FAIL top_word_intact: got %h/%b want a5a5c3c3/0", rd, er); end
    do_access(1'b0, 1'b0, 32'h00, 32'h0, rd, er, lat, busy);
    checks++; if (rd !== 32'h11111111) begin fails++; $display("FAIL word0_intact: got %h want 11111111", rd); end
    do_access(1'b0, 1'b1, 32'hFF, 32'h0, rd, er, lat, busy);
    checks++; if (rd !== 32'h000000A5 || er !== 1'b0) begin fails++; $display("FAIL last_byte: got %h/%b want 000000a5/0", rd, er); end
    do_access(1'b0, 1'b1, 32'h100, 32'h0, rd, er, lat, busy);
    checks++; if (rd !== 32'h0 || er !== 1'b1) begin fails++; $display("FAIL range_byte_load: got %h/%b want 0/1", rd, er); end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy, exp_vld;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    @(posedge clk);
    #1;
    req_byte = 1'b1;
    req_addr = 32'h12;
    for (int k = 1; k <= 2 * LAT + 2; k++) begin
      @(negedge clk);
      exp_rdy = !((k >= 1 && k <= LAT) || (k >= LAT + 2 && k <= 2 * LAT + 1));
      exp_vld = (k == LAT + 1) || (k == 2 * LAT + 2);
      checks++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL b2b_ready[%0d]: got %b want %b", k, req_ready, exp_rdy); end
      checks++; if (resp_valid !== exp_vld) begin fails++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, resp_valid, exp_vld); end
      if (k == LAT + 1) begin
        checks++; if (resp_rdata !== 32'hDE5ABEEF || resp_error !== 1'b0) begin fails++; $display("FAIL b2b_first_data: got %h/%b want de5abeef/0", resp_rdata, resp_error); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
      end
      if (k == 2 * LAT + 2) begin
        checks++; if (resp_rdata !== 32'h0000005A || resp_error !== 1'b0) begin fails++; $display("FAIL b2b_second_data: got %h/%b want 0000005a/0", resp_rdata, resp_error); end
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd;
    logic er;
    int lat, busy;
    int seen;
    do_access(1'b1, 1'b0, 32'h20, 32'h0BADCAFE, rd, er, lat, busy);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_byte  = 1'b0;
    req_addr  = 32'h20;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (state_dbg !== IDLE) begin fails++; $display("FAIL midreset_state: got %0d want %0d", state_dbg, IDLE); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b want 1", req_ready); end
    checks++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL midreset_rdata: got %h want 0", resp_rdata); end
    #2;
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checks++; if (seen !== 0) begin fails++; $display("FAIL midreset_no_resp: got %0d pulses want 0", seen); end
    do_access(1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, busy);
    checks++; if (rd !== 32'h0BADCAFE) begin fails++; $display("FAIL store_dropped: got %h want 0badcafe", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, a, d;
    logic er, exp_er, w, b;
    logic [32:0] e;
    int lat, busy;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      model_access(1'b1, 1'b0, i * 4, d, exp_rd, exp_er);
      do_access(1'b1, 1'b0, i * 4, d, rd, er, lat, busy);
    end
    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = $urandom_range(0, DEPTH * 4 + 15);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      if (!b && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d = $urandom;
      model_access(w, b, a, d, exp_rd, exp_er);
      exp_q.push_back({exp_er, exp_rd});
      do_access(w, b, a, d, rd, er, lat, busy);
      e = exp_q.pop_front();
      checks++; if ({er, rd} !== e) begin fails++; $display("FAIL rand_resp[%0d] w=%b b=%b a=%h: got %b/%h want %b/%h", n, w, b, a, er, rd, e[32], e[31:0]); end
      checks++; if (lat !== LAT) begin fails++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, LAT); end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_loads();
    test_byte_store();
    test_errors();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
